// File: rtl/vx_dispatch_credit_pkg.sv
// Shared constants for the credit-gated dispatch stage: perf counter width,
// credit counter width and the minimum-one log2 used for index widths.
package vx_dispatch_credit_pkg;

    localparam int PERF_CTR_BITS = 32;
    localparam int CRD_W         = 8;

    function automatic int unsigned log2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vx_dispatch_credit_ctr.sv
// Per lane-unit downstream credit counter with sticky overflow flag.
// Fire and return in the same cycle cancel; a return at full credit is dropped and flagged.
module vx_dispatch_credit_ctr
    import vx_dispatch_credit_pkg::*;
#(
    parameter int CREDITS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic fire,
    input  logic ret,
    output logic avail,
    output logic overflow
);

    localparam logic [CRD_W-1:0] CRD_MAX = CRD_W'(CREDITS);

    logic [CRD_W-1:0] credit_q, credit_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (fire && !ret) begin
            credit_d = credit_q - CRD_W'(1);
        end else if (ret && !fire) begin
            if (credit_q == CRD_MAX) begin
                ovf_d = 1'b1;
            end else begin
                credit_d = credit_q + CRD_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            credit_q <= CRD_MAX;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign avail    = (credit_q != '0);
    assign overflow = ovf_q;

endmodule

// File: rtl/vx_dispatch_credit.sv
// Credit-gated dispatch: each lane routes into a per-(lane,unit) FIFO released under downstream credit.
// Optional perf counters are built only when DISPATCH_PERF_EN is defined.
module vx_dispatch_credit
    import vx_dispatch_credit_pkg::*;
#(
    parameter  int NUM_LANES   = 1,
    parameter  int NUM_UNITS   = 4,
    parameter  int DATAW       = 64,
    parameter  int NUM_THREADS = 4,
    parameter  int DEPTH       = 2,
    parameter  int CREDITS     = 4,
    localparam int EXW         = int'(log2_min1(NUM_UNITS)),
    localparam int TIDW        = int'(log2_min1(NUM_THREADS)),
    localparam int ENTW        = DATAW + NUM_THREADS + TIDW
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_LANES-1:0]                in_valid,
    output logic [NUM_LANES-1:0]                in_ready,
    input  logic [NUM_LANES*EXW-1:0]            in_ex_type,
    input  logic [NUM_LANES*NUM_THREADS-1:0]    in_tmask,
    input  logic [NUM_LANES*DATAW-1:0]          in_data,
    output logic [NUM_LANES*NUM_UNITS-1:0]      out_valid,
    input  logic [NUM_LANES*NUM_UNITS-1:0]      out_ready,
    output logic [NUM_LANES*NUM_UNITS*ENTW-1:0] out_data,
    input  logic [NUM_LANES*NUM_UNITS-1:0]      crd_return,
    output logic [1:0]                          err
`ifdef DISPATCH_PERF_EN
    ,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0]  perf_stalls,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0]  perf_fires,
    output logic [NUM_UNITS*PERF_CTR_BITS-1:0]  perf_nocredit
`endif
);

    localparam int NB = NUM_LANES * NUM_UNITS;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [EXW:0] NUM_UNITS_EXT = (EXW+1)'(NUM_UNITS);

    logic [NB-1:0]             buf_full;
    logic [NB-1:0]             buf_empty;
    logic [NB-1:0]             buf_enq;
    logic [NB-1:0]             buf_deq;
    logic [NB-1:0]             crd_avail;
    logic [NB-1:0]             crd_ovf;
    logic [NUM_LANES-1:0]      lane_bad;
    logic [NUM_LANES*ENTW-1:0] lane_entry;
    logic                      bad_q, bad_d;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic [EXW-1:0]         ex;
        logic [NUM_THREADS-1:0] tmask;
        logic [NUM_THREADS-1:0] tmask_sh;
        logic [TIDW-1:0]        last_tid;
        logic [NUM_UNITS-1:0]   unit_ok;

        assign ex          = in_ex_type[l*EXW +: EXW];
        assign tmask       = in_tmask[l*NUM_THREADS +: NUM_THREADS];
        assign lane_bad[l] = ({1'b0, ex} >= NUM_UNITS_EXT);

        // Ascending scan: the highest set thread wins; all-zero mask leaves 0.
        always_comb begin
            last_tid = '0;
            tmask_sh = '0;
            for (int unsigned t = 0; t < NUM_THREADS; t++) begin
                tmask_sh = tmask >> t;
                if (tmask_sh[0]) begin
                    last_tid = TIDW'(t);
                end
            end
        end

        assign lane_entry[l*ENTW +: ENTW] = {in_data[l*DATAW +: DATAW], tmask, last_tid};

        for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
            assign unit_ok[u] = (ex == EXW'(u)) && !buf_full[l*NUM_UNITS + u];
            assign buf_enq[l*NUM_UNITS + u] = in_valid[l] && !reset && unit_ok[u];
        end

        // Out-of-range unit types are swallowed so the lane never wedges.
        assign in_ready[l] = !reset && (lane_bad[l] || (|unit_ok));
    end

    always_comb begin
        bad_d = bad_q | (|(in_valid & lane_bad));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_q <= 1'b0;
        end else begin
            bad_q <= bad_d;
        end
    end

    assign err = {|crd_ovf, bad_q};

    for (genvar k = 0; k < NB; k++) begin : g_buf
        localparam int LANE = k / NUM_UNITS;

        logic [ENTW-1:0] mem_q [DEPTH];
        logic [ENTW-1:0] mem_d [DEPTH];
        logic [PW-1:0]   wptr_q, wptr_d;
        logic [PW-1:0]   rptr_q, rptr_d;
        logic [CW-1:0]   cnt_q, cnt_d;

        assign buf_full[k]  = (cnt_q == CW'(DEPTH));
        assign buf_empty[k] = (cnt_q == '0);
        assign out_valid[k] = !reset && !buf_empty[k] && crd_avail[k];
        assign buf_deq[k]   = out_valid[k] && out_ready[k];
        assign out_data[k*ENTW +: ENTW] = mem_q[rptr_q];

        always_comb begin
            mem_d  = mem_q;
            wptr_d = wptr_q;
            rptr_d = rptr_q;
            if (buf_enq[k]) begin
                mem_d[wptr_q] = lane_entry[LANE*ENTW +: ENTW];
                wptr_d        = wptr_q + PW'(1);
            end
            if (buf_deq[k]) begin
                rptr_d = rptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(buf_enq[k]) - CW'(buf_deq[k]);
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                wptr_q <= wptr_d;
                rptr_q <= rptr_d;
                cnt_q  <= cnt_d;
            end
            mem_q <= mem_d;
        end

        vx_dispatch_credit_ctr #(
            .CREDITS (CREDITS)
        ) u_ctr (
            .clk      (clk),
            .reset    (reset),
            .fire     (buf_deq[k]),
            .ret      (crd_return[k]),
            .avail    (crd_avail[k]),
            .overflow (crd_ovf[k])
        );
    end

`ifdef DISPATCH_PERF_EN
    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_perf
        logic [NUM_LANES-1:0]     stall_v, fire_v, nocr_v;
        logic [PERF_CTR_BITS-1:0] stalls_q, stalls_d;
        logic [PERF_CTR_BITS-1:0] fires_q, fires_d;
        logic [PERF_CTR_BITS-1:0] nocr_q, nocr_d;

        for (genvar l = 0; l < NUM_LANES; l++) begin : g_pl
            assign stall_v[l] = out_valid[l*NUM_UNITS + u] && !out_ready[l*NUM_UNITS + u];
            assign fire_v[l]  = buf_deq[l*NUM_UNITS + u];
            assign nocr_v[l]  = !buf_empty[l*NUM_UNITS + u] && !crd_avail[l*NUM_UNITS + u];
        end

        always_comb begin
            stalls_d = stalls_q + PERF_CTR_BITS'($countones(stall_v));
            fires_d  = fires_q + PERF_CTR_BITS'($countones(fire_v));
            nocr_d   = nocr_q + PERF_CTR_BITS'($countones(nocr_v));
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                stalls_q <= '0;
                fires_q  <= '0;
                nocr_q   <= '0;
            end else begin
                stalls_q <= stalls_d;
                fires_q  <= fires_d;
                nocr_q   <= nocr_d;
            end
        end

        assign perf_stalls[u*PERF_CTR_BITS +: PERF_CTR_BITS]   = stalls_q;
        assign perf_fires[u*PERF_CTR_BITS +: PERF_CTR_BITS]    = fires_q;
        assign perf_nocredit[u*PERF_CTR_BITS +: PERF_CTR_BITS] = nocr_q;
    end
`endif

endmodule
